// File: rtl/udp_rx_pkg.sv
// Shared types and constants for the UDP receive path.
package udp_rx_pkg;

  localparam logic [15:0] UDP_HDR_LEN = 16'd8;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrShortHdr = 2'd1,
    ErrBadLen   = 2'd2,
    ErrTrunc    = 2'd3
  } udp_rx_err_e;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StData,
    StDiscard
  } udp_rx_state_e;

  typedef struct packed {
    logic        is_valid;
    logic [31:0] src_ip_addr;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] data_length;
  } udp_rx_header_type;

  typedef struct packed {
    udp_rx_header_type hdr;
    logic [7:0]        data;
    logic              data_valid;
    logic              data_last;
  } udp_rx_type;

  // A UDP length must cover its own header and fit inside the IP payload.
  function automatic logic hdr_len_bad(input logic [15:0] udp_len, input logic [15:0] ip_len);
    return (udp_len < UDP_HDR_LEN) || (udp_len > ip_len);
  endfunction

endpackage

// File: rtl/udp_rx_hdr_capture.sv
// Shifts in the first seven UDP header bytes; fields are decoded while byte 7 is on the input.
module udp_rx_hdr_capture
  import udp_rx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        shift_en,
  input  logic [7:0]  data_in,
  input  logic [15:0] ip_len,
  output logic [15:0] src_port,
  output logic [15:0] dst_port,
  output logic [15:0] udp_len,
  output logic        len_bad
);

  logic [55:0] shreg_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
    end else if (shift_en) begin
      shreg_q <= {shreg_q[47:0], data_in};
    end
  end

  assign src_port = shreg_q[55:40];
  assign dst_port = shreg_q[39:24];
  assign udp_len  = shreg_q[23:8];
  assign len_bad  = hdr_len_bad(udp_len, ip_len);

endmodule

// File: rtl/udp_rx.sv
// UDP receive layer: filters IP payloads on protocol, strips the 8-byte header and forwards
// user data with one cycle of latency, counting malformed datagrams.
module udp_rx
  import udp_rx_pkg::*;
#(
  parameter logic [7:0]  UDP_PROTO = 8'h11,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ip_rx_start,
  input  logic                 ip_rx_hdr_is_valid,
  input  logic [7:0]           ip_rx_hdr_protocol,
  input  logic [15:0]          ip_rx_hdr_data_length,
  input  logic [31:0]          ip_rx_hdr_src_ip_addr,
  input  logic [7:0]           ip_rx_data_in,
  input  logic                 ip_rx_data_in_valid,
  input  logic                 ip_rx_data_in_last,
  output logic                 udp_rx_start,
  output logic                 udp_rx_hdr_is_valid,
  output logic [31:0]          udp_rx_hdr_src_ip_addr,
  output logic [15:0]          udp_rx_hdr_src_port,
  output logic [15:0]          udp_rx_hdr_dst_port,
  output logic [15:0]          udp_rx_hdr_data_length,
  output logic [7:0]           udp_rx_data_out,
  output logic                 udp_rx_data_out_valid,
  output logic                 udp_rx_data_out_last,
  output logic [ERR_CNT_W-1:0] udp_rx_err_cnt,
  output logic [1:0]           udp_rx_err_code
);

  udp_rx_state_e        state_q;
  udp_rx_type           rx_q;
  udp_rx_err_e          err_code_q;
  logic                 start_q;
  logic [15:0]          cnt_q;
  logic [15:0]          ip_len_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_inc;

  logic [15:0] cap_src_port;
  logic [15:0] cap_dst_port;
  logic [15:0] cap_udp_len;
  logic        cap_len_bad;
  logic        hdr_shift;

  // A new start always wins over a byte in the same cycle.
  assign hdr_shift = (state_q == StHdr) && ip_rx_data_in_valid && !ip_rx_start;

  udp_rx_hdr_capture u_hdr_capture (
    .clk      (clk),
    .reset    (reset),
    .shift_en (hdr_shift),
    .data_in  (ip_rx_data_in),
    .ip_len   (ip_len_q),
    .src_port (cap_src_port),
    .dst_port (cap_dst_port),
    .udp_len  (cap_udp_len),
    .len_bad  (cap_len_bad)
  );

  assign err_cnt_inc = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      rx_q       <= '0;
      err_code_q <= ErrNone;
      start_q    <= 1'b0;
      cnt_q      <= '0;
      ip_len_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      start_q         <= 1'b0;
      rx_q.data_valid <= 1'b0;
      rx_q.data_last  <= 1'b0;
      if (ip_rx_start) begin
        if (state_q == StData) begin
          err_code_q <= ErrTrunc;
          err_cnt_q  <= err_cnt_inc;
        end
        rx_q.hdr.is_valid <= 1'b0;
        cnt_q             <= '0;
        ip_len_q          <= ip_rx_hdr_data_length;
        if (ip_rx_hdr_is_valid && (ip_rx_hdr_protocol == UDP_PROTO)) begin
          rx_q.hdr.src_ip_addr <= ip_rx_hdr_src_ip_addr;
          state_q              <= StHdr;
        end else begin
          state_q <= StDiscard;
        end
      end else if (ip_rx_data_in_valid) begin
        unique case (state_q)
          StIdle: ;
          StHdr: begin
            if (cnt_q == 16'd7) begin
              cnt_q <= '0;
              if (cap_len_bad) begin
                err_code_q <= ErrBadLen;
                err_cnt_q  <= err_cnt_inc;
                state_q    <= ip_rx_data_in_last ? StIdle : StDiscard;
              end else begin
                start_q              <= 1'b1;
                rx_q.hdr.is_valid    <= 1'b1;
                rx_q.hdr.src_port    <= cap_src_port;
                rx_q.hdr.dst_port    <= cap_dst_port;
                rx_q.hdr.data_length <= cap_udp_len - UDP_HDR_LEN;
                if (cap_udp_len == UDP_HDR_LEN) begin
                  state_q <= ip_rx_data_in_last ? StIdle : StDiscard;
                end else if (ip_rx_data_in_last) begin
                  // Header promised payload but the IP stream already ended.
                  err_code_q <= ErrTrunc;
                  err_cnt_q  <= err_cnt_inc;
                  state_q    <= StIdle;
                end else begin
                  state_q <= StData;
                end
              end
            end else if (ip_rx_data_in_last) begin
              err_code_q <= ErrShortHdr;
              err_cnt_q  <= err_cnt_inc;
              state_q    <= StIdle;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          StData: begin
            rx_q.data       <= ip_rx_data_in;
            rx_q.data_valid <= 1'b1;
            cnt_q           <= cnt_q + 16'd1;
            if ((cnt_q + 16'd1) == rx_q.hdr.data_length) begin
              rx_q.data_last <= 1'b1;
              state_q        <= ip_rx_data_in_last ? StIdle : StDiscard;
            end else if (ip_rx_data_in_last) begin
              rx_q.data_last <= 1'b1;
              err_code_q     <= ErrTrunc;
              err_cnt_q      <= err_cnt_inc;
              state_q        <= StIdle;
            end
          end
          StDiscard: begin
            if (ip_rx_data_in_last) begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign udp_rx_start           = start_q;
  assign udp_rx_hdr_is_valid    = rx_q.hdr.is_valid;
  assign udp_rx_hdr_src_ip_addr = rx_q.hdr.src_ip_addr;
  assign udp_rx_hdr_src_port    = rx_q.hdr.src_port;
  assign udp_rx_hdr_dst_port    = rx_q.hdr.dst_port;
  assign udp_rx_hdr_data_length = rx_q.hdr.data_length;
  assign udp_rx_data_out        = rx_q.data;
  assign udp_rx_data_out_valid  = rx_q.data_valid;
  assign udp_rx_data_out_last   = rx_q.data_last;
  assign udp_rx_err_cnt         = err_cnt_q;
  assign udp_rx_err_code        = err_code_q;

endmodule

// File: tb/tb_udp_rx.sv
// Directed and random datagrams checked against a datagram-level reference model.
module tb_udp_rx;

  localparam int ERR_MAX = 255;

  logic        clk;
  logic        reset;
  logic        ip_rx_start;
  logic        ip_rx_hdr_is_valid;
  logic [7:0]  ip_rx_hdr_protocol;
  logic [15:0] ip_rx_hdr_data_length;
  logic [31:0] ip_rx_hdr_src_ip_addr;
  logic [7:0]  ip_rx_data_in;
  logic        ip_rx_data_in_valid;
  logic        ip_rx_data_in_last;
  logic        udp_rx_start;
  logic        udp_rx_hdr_is_valid;
  logic [31:0] udp_rx_hdr_src_ip_addr;
  logic [15:0] udp_rx_hdr_src_port;
  logic [15:0] udp_rx_hdr_dst_port;
  logic [15:0] udp_rx_hdr_data_length;
  logic [7:0]  udp_rx_data_out;
  logic        udp_rx_data_out_valid;
  logic        udp_rx_data_out_last;
  logic [7:0]  udp_rx_err_cnt;
  logic [1:0]  udp_rx_err_code;

  udp_rx dut (
    .clk                    (clk),
    .reset                  (reset),
    .ip_rx_start            (ip_rx_start),
    .ip_rx_hdr_is_valid     (ip_rx_hdr_is_valid),
    .ip_rx_hdr_protocol     (ip_rx_hdr_protocol),
    .ip_rx_hdr_data_length  (ip_rx_hdr_data_length),
    .ip_rx_hdr_src_ip_addr  (ip_rx_hdr_src_ip_addr),
    .ip_rx_data_in          (ip_rx_data_in),
    .ip_rx_data_in_valid    (ip_rx_data_in_valid),
    .ip_rx_data_in_last     (ip_rx_data_in_last),
    .udp_rx_start           (udp_rx_start),
    .udp_rx_hdr_is_valid    (udp_rx_hdr_is_valid),
    .udp_rx_hdr_src_ip_addr (udp_rx_hdr_src_ip_addr),
    .udp_rx_hdr_src_port    (udp_rx_hdr_src_port),
    .udp_rx_hdr_dst_port    (udp_rx_hdr_dst_port),
    .udp_rx_hdr_data_length (udp_rx_hdr_data_length),
    .udp_rx_data_out        (udp_rx_data_out),
    .udp_rx_data_out_valid  (udp_rx_data_out_valid),
    .udp_rx_data_out_last   (udp_rx_data_out_last),
    .udp_rx_err_cnt         (udp_rx_err_cnt),
    .udp_rx_err_code        (udp_rx_err_code)
  );

  int          total = 0;
  int          passed = 0;
  int unsigned cyc = 0;
  int          exp_cnt = 0;
  logic [1:0]  exp_code = 2'd0;

  logic [7:0]   tx[$];
  int unsigned  cc[$];
  logic [111:0] got_st[$];
  logic [111:0] exp_st[$];
  logic [40:0]  got_dt[$];
  logic [40:0]  exp_dt[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      if (udp_rx_start) begin
        got_st.push_back({cyc, udp_rx_hdr_src_ip_addr, udp_rx_hdr_src_port,
                          udp_rx_hdr_dst_port, udp_rx_hdr_data_length});
      end
      if (udp_rx_data_out_valid) begin
        got_dt.push_back({cyc, udp_rx_data_out_last, udp_rx_data_out});
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Drives one datagram; nbytes below tx.size() stops early without a last.
  task automatic send(input bit hv, input logic [7:0] proto, input logic [15:0] iplen,
                      input logic [31:0] sip, input bit gaps, input int nbytes);
    @(posedge clk); #1;
    ip_rx_start           = 1'b1;
    ip_rx_hdr_is_valid    = hv;
    ip_rx_hdr_protocol    = proto;
    ip_rx_hdr_data_length = iplen;
    ip_rx_hdr_src_ip_addr = sip;
    @(posedge clk); #1;
    ip_rx_start = 1'b0;
    cc.delete();
    for (int i = 0; i < nbytes; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      ip_rx_data_in       = tx[i];
      ip_rx_data_in_valid = 1'b1;
      ip_rx_data_in_last  = (i == int'(tx.size()) - 1);
      cc.push_back(cyc + 1);
      @(posedge clk); #1;
      ip_rx_data_in_valid = 1'b0;
      ip_rx_data_in_last  = 1'b0;
    end
  endtask

  task automatic model_err(input logic [1:0] code);
    exp_code = code;
    if (exp_cnt < ERR_MAX) exp_cnt++;
  endtask

  // Expected outcome of one complete datagram, from its lengths alone.
  task automatic model(input bit ok, input logic [15:0] iplen, input logic [31:0] sip);
    int n;
    int avail;
    int nout;
    logic [15:0] ul;
    logic [15:0] dl;
    n = int'(tx.size());
    exp_st.delete();
    exp_dt.delete();
    if (!ok) return;
    if (n < 8) begin
      model_err(2'd1);
      return;
    end
    ul = {tx[4], tx[5]};
    if (ul < 16'd8 || ul > iplen) begin
      model_err(2'd2);
      return;
    end
    dl = ul - 16'd8;
    exp_st.push_back({cc[7], sip, tx[0], tx[1], tx[2], tx[3], dl});
    avail = n - 8;
    nout  = (int'(dl) < avail) ? int'(dl) : avail;
    for (int i = 0; i < nout; i++) begin
      exp_dt.push_back({cc[8 + i], (i == nout - 1), tx[8 + i]});
    end
    if (avail < int'(dl)) model_err(2'd3);
  endtask

  task automatic compare(input string tag);
    chk({tag, " start count"}, 128'(got_st.size()), 128'(exp_st.size()));
    for (int i = 0; i < got_st.size() && i < exp_st.size(); i++) begin
      chk({tag, " header"}, 128'(got_st[i]), 128'(exp_st[i]));
    end
    chk({tag, " byte count"}, 128'(got_dt.size()), 128'(exp_dt.size()));
    for (int i = 0; i < got_dt.size() && i < exp_dt.size(); i++) begin
      chk({tag, " byte"}, 128'(got_dt[i]), 128'(exp_dt[i]));
    end
    chk({tag, " hdr_is_valid"}, 128'(udp_rx_hdr_is_valid), 128'(exp_st.size() != 0));
    chk({tag, " err_code"}, 128'(udp_rx_err_code), 128'(exp_code));
    chk({tag, " err_cnt"}, 128'(udp_rx_err_cnt), 128'(exp_cnt));
    got_st.delete();
    got_dt.delete();
  endtask

  task automatic run_one(input string tag, input bit hv, input logic [7:0] proto,
                         input logic [15:0] iplen, input logic [31:0] sip, input bit gaps);
    send(hv, proto, iplen, sip, gaps, int'(tx.size()));
    repeat (3) @(posedge clk);
    #1;
    model(hv && proto == 8'h11, iplen, sip);
    compare(tag);
  endtask

  task automatic load_nominal();
    tx = '{8'h04, 8'hD2, 8'h16, 8'h2E, 8'h00, 8'h0C, 8'h00, 8'h00,
           8'hAA, 8'hBB, 8'hCC, 8'hDD};
  endtask

  initial begin
    int n;
    logic [15:0] iplen;
    logic [15:0] ul;
    logic [7:0] pr;
    bit hv;

    reset = 1'b1;
    ip_rx_start = 1'b0;
    ip_rx_hdr_is_valid = 1'b0;
    ip_rx_hdr_protocol = 8'h00;
    ip_rx_hdr_data_length = 16'h0;
    ip_rx_hdr_src_ip_addr = 32'h0;
    ip_rx_data_in = 8'h00;
    ip_rx_data_in_valid = 1'b0;
    ip_rx_data_in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset start", 128'(udp_rx_start), 128'(0));
    chk("reset valid", 128'(udp_rx_data_out_valid), 128'(0));
    chk("reset err", 128'({udp_rx_err_cnt, udp_rx_err_code}), 128'(0));
    reset = 1'b0;

    load_nominal();
    run_one("nominal", 1'b1, 8'h11, 16'd12, 32'hC0A8_0001, 1'b0);
    chk("nominal src_port", 128'(udp_rx_hdr_src_port), 128'(16'h04D2));
    chk("nominal dst_port", 128'(udp_rx_hdr_dst_port), 128'(16'h162E));
    chk("nominal data_length", 128'(udp_rx_hdr_data_length), 128'(16'd4));
    chk("nominal last data", 128'(udp_rx_data_out), 128'(8'hDD));

    load_nominal();
    run_one("proto filter", 1'b1, 8'h06, 16'd12, 32'hC0A8_0002, 1'b0);

    tx = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h0A, 8'hBE, 8'hEF,
           8'h11, 8'h22, 8'h01, 8'h02, 8'h03, 8'h04};
    run_one("padding", 1'b1, 8'h11, 16'd14, 32'h0A00_0001, 1'b0);
    load_nominal();
    run_one("after padding", 1'b1, 8'h11, 16'd12, 32'h0A00_0002, 1'b1);

    tx = '{8'h00, 8'h35, 8'h00, 8'h35, 8'h00, 8'h10, 8'h00, 8'h00,
           8'h5A, 8'h6B, 8'h7C};
    run_one("truncation", 1'b1, 8'h11, 16'd24, 32'h0A00_0003, 1'b0);
    chk("truncation err_code", 128'(udp_rx_err_code), 128'(2'd3));
    chk("truncation err_cnt", 128'(udp_rx_err_cnt), 128'(8'd1));

    tx = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h00};
    run_one("bad length", 1'b1, 8'h11, 16'd8, 32'h0A00_0004, 1'b0);
    chk("bad length err_code", 128'(udp_rx_err_code), 128'(2'd2));

    tx = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00};
    run_one("short header", 1'b1, 8'h11, 16'd5, 32'h0A00_0005, 1'b0);
    chk("short header err_code", 128'(udp_rx_err_code), 128'(2'd1));

    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(1, 24);
      iplen = 16'(n);
      if ($urandom_range(0, 3) == 0) iplen = iplen + 16'($urandom_range(1, 6));
      pr = ($urandom_range(0, 3) == 0) ? 8'h06 : 8'h11;
      hv = ($urandom_range(0, 7) != 0);
      tx.delete();
      for (int i = 0; i < n; i++) tx.push_back(8'($urandom_range(0, 255)));
      if (n >= 6) begin
        ul = 16'($urandom_range(0, int'(iplen) + 3));
        tx[4] = ul[15:8];
        tx[5] = ul[7:0];
      end
      run_one("random", hv, pr, iplen, $urandom, 1'b1);
    end

    tx = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h00};
    for (int k = 0; k < 300; k++) begin
      send(1'b1, 8'h11, 16'd8, 32'h0, 1'b0, 8);
      model(1'b1, 16'd8, 32'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    compare("saturation");
    chk("saturation err_cnt", 128'(udp_rx_err_cnt), 128'(8'hFF));

    load_nominal();
    send(1'b1, 8'h11, 16'd12, 32'h0A00_0006, 1'b0, 10);
    #2;
    reset = 1'b1;
    #1;
    chk("mid reset hdr", 128'({udp_rx_start, udp_rx_hdr_is_valid, udp_rx_hdr_src_ip_addr,
                               udp_rx_hdr_src_port, udp_rx_hdr_dst_port,
                               udp_rx_hdr_data_length}), 128'(0));
    chk("mid reset data", 128'({udp_rx_data_out, udp_rx_data_out_valid,
                                udp_rx_data_out_last}), 128'(0));
    chk("mid reset err", 128'({udp_rx_err_cnt, udp_rx_err_code}), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    got_st.delete();
    got_dt.delete();
    exp_cnt = 0;
    exp_code = 2'd0;
    load_nominal();
    run_one("after reset", 1'b1, 8'h11, 16'd12, 32'hC0A8_0007, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/udp_rx.md
Name: udp_rx

Overview:
- Receive-side counterpart of the UDP transmit path.
- Consumes the IPv4 RX payload byte stream (header fields plus bytes) from the IP layer.
- Filters on protocol 0x11 and strips the 8-byte UDP header.
- Presents a UDP RX header and the user-data byte stream to the application layer, with a registered datapath and error reporting for malformed datagrams.

Parameters:
- UDP_PROTO, 8'h11: IP protocol number accepted.
- ERR_CNT_W, 8: width of saturating error counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ip_rx_start  in  1  one-cycle pulse: IP header fields valid, payload follows
- ip_rx_hdr_is_valid  in  1  IP header passed checks
- ip_rx_hdr_protocol  in  8  IP protocol field
- ip_rx_hdr_data_length  in  16  IP payload length in bytes
- ip_rx_hdr_src_ip_addr  in  32  source IP
- ip_rx_data_in  in  8  payload byte
- ip_rx_data_in_valid  in  1  byte strobe
- ip_rx_data_in_last  in  1  final payload byte
- udp_rx_start  out  1  one-cycle pulse: UDP header outputs valid
- udp_rx_hdr_is_valid  out  1  header fields valid (held)
- udp_rx_hdr_src_ip_addr  out  32  latched source IP
- udp_rx_hdr_src_port  out  16  UDP source port
- udp_rx_hdr_dst_port  out  16  UDP destination port
- udp_rx_hdr_data_length  out  16  UDP length minus 8
- udp_rx_data_out  out  8  user byte
- udp_rx_data_out_valid  out  1  user byte strobe
- udp_rx_data_out_last  out  1  final user byte
- udp_rx_err_cnt  out  ERR_CNT_W  saturating count of dropped/truncated datagrams
- udp_rx_err_code  out  2  last error: 0 none, 1 short header, 2 bad length, 3 truncated

Behaviour:
- Reset (async) clears all outputs to 0, state to IDLE, and byte counter to 0.
- No backpressure. Every valid input byte is consumed in its cycle.
- FSM states:
  - IDLE: on ip_rx_start with hdr_is_valid=1 and protocol==UDP_PROTO, latch src_ip and go to HDR. On any other ip_rx_start, go to DISCARD. Bytes arriving without a start are ignored.
  - HDR: capture bytes 0-7 big-endian (src_port, dst_port, udp_len, checksum; checksum stored, not checked). Byte counter counts 0..7.
    - At byte 7: if udp_len<8 or udp_len>ip_rx_hdr_data_length (latched), set err_code=2, increment err_cnt, go to DISCARD.
    - Otherwise, next cycle: udp_rx_start=1 for exactly one cycle, hdr_is_valid=1, data_length=udp_len-8.
    - If data_length==0, go to DISCARD (or IDLE if byte 7 carried last); otherwise go to DATA.
    - ip last before byte 7: err_code=1, err_cnt++, return to IDLE, no udp_rx_start.
  - DATA: forward each byte with latency 1 (registered out=in, valid=in_valid). Count bytes.
    - udp_rx_data_out_last=1 on the byte where count==data_length, then go to DISCARD. If that byte also carries in_last, go to IDLE.
    - ip last before the count is reached: output that byte with last=1, err_code=3, err_cnt++, go to IDLE.
  - DISCARD: drop bytes until in_last, then go to IDLE (IP padding beyond udp_len is silently dropped).
- hdr_is_valid stays 1 until the next udp_rx_start cycle or the next ip_rx_start, then clears.
- ip_rx_start in a non-IDLE state aborts the current datagram. If in DATA, emit no last; count an err_code=3 error. The new start is processed as if in IDLE the same cycle.
- err_cnt saturates at all-ones. err_code holds its last value and is cleared only by reset.
- Byte counter is 16 bits. A header-length subtraction result is only used after the udp_len>=8 check (no wrap).

Decomposition:
- global_typs_pkg gains:
  - udp_rx_header_type (is_valid, src_ip_addr, src_port, dst_port, data_length)
  - udp_rx_type (hdr + data bundle)
  - udp_rx_err_e enum
  - UDP_HDR_LEN=8 constant
- The header byte capture is a natural sub-module, udp_rx_hdr_capture: shift-in of 8 bytes and length checks. The FSM and datapath stay in udp_rx.

Test Plan:
- Nominal: proto 0x11, ip len 12, bytes 04 D2 16 2E 00 0C 00 00 AA BB CC DD -> udp_rx_start pulse 1 cycle after byte 7; src_port 0x04D2, dst_port 0x162E, data_length 4; outputs AA BB CC DD, each 1 cycle after input, last on DD; err_cnt 0.
- Protocol filter: proto 0x06, same bytes -> no udp_rx_start, no valid outputs, err_cnt 0.
- IP padding: ip len 14, udp_len 0x000A, payload 11 22 + 4 pad bytes -> outputs 11 22 with last on 22; pad bytes dropped; next datagram received normally.
- Truncation: udp_len 0x0010, ip last after 3 payload bytes -> 3 bytes output, last on 3rd; err_code 3, err_cnt 1.
- Bad and short headers:
  - udp_len 0x0004 -> err_code 2, no start.
  - ip last after 5 bytes -> err_code 1.
  - 300 bad datagrams with ERR_CNT_W=8 -> err_cnt 255.
- Reset mid-DATA: assert reset after 2 payload bytes -> all outputs 0 immediately; the following good datagram decodes correctly.
